// File: rtl/ckm_pkg.sv
// Shared definitions for the clock-manager sequencer: state encoding,
// default timing constants and small elaboration-time helpers.
package ckm_pkg;

  typedef enum logic [2:0] {
    RST_DCM   = 3'd0,
    WAIT_LOCK = 3'd1,
    SETTLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } ckm_state_t;

  localparam int CKM_N_DCM         = 3;
  localparam int CKM_RST_CYCLES    = 4;
  localparam int CKM_LOCK_TIMEOUT  = 100000;
  localparam int CKM_SETTLE_CYCLES = 1024;
  localparam int CKM_STAGE_GAP     = 16;
  localparam int CKM_MAX_RETRY     = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_rst_sequencer_if.sv
// DCM lock/reset bundle between the sequencer (master) and the clock
// manager / reset consumers (slave).
interface clk_rst_sequencer_if #(
  parameter int N_DCM = 3,
  parameter int RC_W  = 2
);
  logic [N_DCM-1:0] dcm_locked;
  logic             dcm_rst;
  logic [N_DCM-1:0] dom_rst;
  logic             xclk_oe;
  logic             ready;
  logic             fault;
  logic [RC_W-1:0]  retry_cnt;

  modport master (
    input  dcm_locked,
    output dcm_rst, dom_rst, xclk_oe, ready, fault, retry_cnt
  );

  modport slave (
    output dcm_locked,
    input  dcm_rst, dom_rst, xclk_oe, ready, fault, retry_cnt
  );
endinterface

// File: rtl/sync_2ff.sv
// Bit-wise two-flop synchronizer; each bit is an independent level signal.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/clk_rst_sequencer.sv
// Power-up / lock-loss sequencer: pulses DCM reset, waits for lock, releases domain
// resets in order. CKM_AUTO_RETRY_EN: retry the DCM reset up to MAX_RETRY times.
module clk_rst_sequencer
  import ckm_pkg::*;
#(
  parameter int N_DCM         = CKM_N_DCM,
  parameter int RST_CYCLES    = CKM_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = CKM_LOCK_TIMEOUT,
  parameter int SETTLE_CYCLES = CKM_SETTLE_CYCLES,
  parameter int STAGE_GAP     = CKM_STAGE_GAP,
  parameter int MAX_RETRY     = CKM_MAX_RETRY
) (
  input  logic                clk,
  input  logic                rst,
  clk_rst_sequencer_if.master bus
);
  localparam int TMR_W = imax(1, clog2(imax(imax(LOCK_TIMEOUT, SETTLE_CYCLES),
                                            imax(RST_CYCLES, STAGE_GAP))));
  localparam int STG_W = imax(1, clog2(N_DCM));
  localparam int RC_W  = imax(1, clog2(MAX_RETRY + 1));

  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETL_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0] STG_LAST  = STG_W'(N_DCM - 1);

  ckm_state_t       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic             dcm_rst_q, dcm_rst_d;
  logic [N_DCM-1:0] dom_q, dom_d;
  logic             oe_q, oe_d;
  logic             rdy_q, rdy_d;
  logic             fault_q, fault_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [N_DCM-1:0] lk_s;
  logic             lk_all;
  logic             fail;

  sync_2ff #(.W(N_DCM)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.dcm_locked),
    .q   (lk_s)
  );

  assign lk_all = &lk_s;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    stage_d   = stage_q;
    dcm_rst_d = dcm_rst_q;
    dom_d     = dom_q;
    oe_d      = oe_q;
    rdy_d     = rdy_q;
    fault_d   = fault_q;
    rc_d      = rc_q;
    fail      = 1'b0;

    case (state_q)
      RST_DCM: begin
        dcm_rst_d = 1'b1;
        dom_d     = '1;
        oe_d      = 1'b0;
        rdy_d     = 1'b0;
        timer_d   = timer_q + TMR_W'(1);
        if (timer_q == RST_LAST) begin
          state_d   = WAIT_LOCK;
          timer_d   = '0;
          dcm_rst_d = 1'b0;
        end
      end
      WAIT_LOCK: begin
        dcm_rst_d = 1'b0;
        timer_d   = timer_q + TMR_W'(1);
        if (lk_all) begin
          state_d = SETTLE;
          timer_d = '0;
        end else if (timer_q == LOCK_LAST) begin
          fail = 1'b1;
        end
      end
      SETTLE: begin
        timer_d = timer_q + TMR_W'(1);
        if (!lk_all) begin
          fail = 1'b1;
        end else if (timer_q == SETL_LAST) begin
          // Domain 0 comes out of reset on the same edge RELEASE is entered.
          state_d  = RELEASE;
          timer_d  = '0;
          stage_d  = '0;
          dom_d[0] = 1'b0;
        end
      end
      RELEASE: begin
        timer_d = timer_q + TMR_W'(1);
        if (!lk_all) begin
          fail = 1'b1;
        end else if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (stage_q == STG_LAST) begin
            state_d = RUN;
            oe_d    = 1'b1;
            rdy_d   = 1'b1;
            rc_d    = '0;
          end else begin
            stage_d = stage_q + STG_W'(1);
            for (int i = 1; i < N_DCM; i++)
              if (stage_q == STG_W'(i - 1)) dom_d[i] = 1'b0;
          end
        end
      end
      RUN: begin
        if (!lk_all) fail = 1'b1;
      end
      FAULT: begin
        dcm_rst_d = 1'b1;
        dom_d     = '1;
        oe_d      = 1'b0;
        rdy_d     = 1'b0;
        fault_d   = 1'b1;
      end
      default: begin
        state_d = FAULT;
        timer_d = '0;
      end
    endcase

    // Timeout and lock-loss share one exit: drop every domain at once.
    if (fail) begin
      dom_d     = '1;
      oe_d      = 1'b0;
      rdy_d     = 1'b0;
      timer_d   = '0;
      stage_d   = '0;
      dcm_rst_d = 1'b1;
`ifdef CKM_AUTO_RETRY_EN
      if (rc_q < RC_W'(MAX_RETRY)) begin
        rc_d    = rc_q + RC_W'(1);
        state_d = RST_DCM;
      end else begin
        state_d = FAULT;
        fault_d = 1'b1;
      end
`else
      state_d = FAULT;
      fault_d = 1'b1;
`endif
    end

`ifndef CKM_AUTO_RETRY_EN
    rc_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_DCM;
      timer_q   <= '0;
      stage_q   <= '0;
      dcm_rst_q <= 1'b1;
      dom_q     <= '1;
      oe_q      <= 1'b0;
      rdy_q     <= 1'b0;
      fault_q   <= 1'b0;
      rc_q      <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      stage_q   <= stage_d;
      dcm_rst_q <= dcm_rst_d;
      dom_q     <= dom_d;
      oe_q      <= oe_d;
      rdy_q     <= rdy_d;
      fault_q   <= fault_d;
      rc_q      <= rc_d;
    end
  end

  assign bus.dcm_rst   = dcm_rst_q;
  assign bus.dom_rst   = dom_q;
  assign bus.xclk_oe   = oe_q;
  assign bus.ready     = rdy_q;
  assign bus.fault     = fault_q;
  assign bus.retry_cnt = rc_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Bench for clk_rst_sequencer: vector table, corner sequences and random lock
// traffic against a timeline model; handles both CKM_AUTO_RETRY_EN builds.
module tb_clk_rst_sequencer;
  localparam int N = 3, RSTC = 4, LT = 50, SC = 8, GAP = 4, MAXR = 2;
`ifdef CKM_AUTO_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clk_rst_sequencer_if #(.N_DCM(N), .RC_W(2)) bus();

  clk_rst_sequencer #(
    .N_DCM(N), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LT),
    .SETTLE_CYCLES(SC), .STAGE_GAP(GAP), .MAX_RETRY(MAXR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0, fails = 0;

  // Timeline model: edge index n, attempt start, settle start, release start.
  int n = 0, m_a = 0, m_ls = -1, m_rs = -1, m_rc = 0;
  bit m_f = 1'b0, h1 = 1'b0, h2 = 1'b0;

  logic [8:0] got;
  assign got = {bus.dcm_rst, bus.dom_rst, bus.xclk_oe, bus.ready, bus.fault, bus.retry_cnt};

  task automatic m_fail();
    if (RETRY && m_rc < MAXR) begin
      m_rc++;
      m_a  = n;
      m_ls = -1;
      m_rs = -1;
    end else begin
      m_f = 1'b1;
    end
  endtask

  task automatic m_edge();
    bit lk;
    n++;
    if (rst) begin
      m_a = n; m_ls = -1; m_rs = -1; m_f = 1'b0; m_rc = 0; h1 = 1'b0; h2 = 1'b0;
      return;
    end
    lk = h2;
    h2 = h1;
    h1 = &bus.dcm_locked;
    if (!m_f) begin
      if (m_rs >= 0) begin
        if (!lk) m_fail();
        else if (n == m_rs + N * GAP) m_rc = 0;
      end else if (m_ls >= 0) begin
        if (!lk) m_fail();
        else if (n == m_ls + SC) m_rs = n;
      end else if (n > m_a + RSTC) begin
        if (lk) m_ls = n;
        else if (n == m_a + RSTC + LT) m_fail();
      end
    end
  endtask

  function automatic logic [8:0] m_exp();
    logic       run;
    logic [2:0] dom;
    run = !m_f && m_rs >= 0 && n >= m_rs + N * GAP;
    for (int i = 0; i < N; i++) dom[i] = !(!m_f && m_rs >= 0 && n >= m_rs + i * GAP);
    return {m_f || (m_ls < 0 && m_rs < 0 && n < m_a + RSTC), dom, run, run, m_f, 2'(m_rc)};
  endfunction

  task automatic tick();
    logic [8:0] e;
    @(posedge clk);
    m_edge();
    #1;
    e = m_exp();
    tests++;
    if (got !== e) begin
      fails++;
      $display("FAIL model n=%0d got=%b exp=%b", n, got, e);
    end
  endtask

  task automatic chk(input string nm, input int g, input int e);
    tests++;
    if (g != e) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, g, e);
    end
  endtask

  task automatic do_reset(input logic [2:0] lock);
    rst = 1'b1;
    bus.dcm_locked = lock;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0] lock;
    int         cyc;
    logic       dcm;
    logic [2:0] dom;
    logic       rdy;
    logic       flt;
    logic [1:0] rc;
  } vec_t;

  vec_t vt[10];

  initial begin
    bus.dcm_locked = 3'b000;
    vt[0] = '{3'b111,   3, 1'b1, 3'b111, 1'b0, 1'b0, 2'd0};
    vt[1] = '{3'b111,   4, 1'b0, 3'b111, 1'b0, 1'b0, 2'd0};
    vt[2] = '{3'b111,  12, 1'b0, 3'b111, 1'b0, 1'b0, 2'd0};
    vt[3] = '{3'b111,  13, 1'b0, 3'b110, 1'b0, 1'b0, 2'd0};
    vt[4] = '{3'b111,  17, 1'b0, 3'b100, 1'b0, 1'b0, 2'd0};
    vt[5] = '{3'b111,  24, 1'b0, 3'b000, 1'b0, 1'b0, 2'd0};
    vt[6] = '{3'b111,  25, 1'b0, 3'b000, 1'b1, 1'b0, 2'd0};
    vt[7] = '{3'b011,  53, 1'b0, 3'b111, 1'b0, 1'b0, 2'd0};
    vt[8] = '{3'b011,  54, 1'b1, 3'b111, 1'b0, !RETRY, RETRY ? 2'd1 : 2'd0};
    vt[9] = '{3'b000, 162, 1'b1, 3'b111, 1'b0, 1'b1,   RETRY ? 2'd2 : 2'd0};

    for (int v = 0; v < 10; v++) begin
      do_reset(vt[v].lock);
      for (int c = 0; c < vt[v].cyc; c++) tick();
      chk($sformatf("vec%0d", v), int'(got),
          int'({vt[v].dcm, vt[v].dom, vt[v].rdy, vt[v].rdy, vt[v].flt, vt[v].rc}));
    end

    // Single-cycle lock glitch while running.
    do_reset(3'b111);
    repeat (25) tick();
    chk("t4_ready_before", bus.ready, 1);
    bus.dcm_locked = 3'b101;
    tick();
    bus.dcm_locked = 3'b111;
    tick();
    tick();
    chk("t4_dom", bus.dom_rst, 7);
    chk("t4_oe", bus.xclk_oe, 0);
    chk("t4_rdy", bus.ready, 0);
    chk("t4_rc_or_fault", RETRY ? int'(bus.retry_cnt) : int'(bus.fault), 1);
    repeat (25) tick();
    chk("t4_rerun", bus.ready, RETRY ? 1 : 0);
    chk("t4_rc0", bus.retry_cnt, 0);

    // Lock drop seen on settle cycle 5 of 8.
    do_reset(3'b111);
    repeat (7) begin
      tick();
      chk("t5_dom_hold", bus.dom_rst, 7);
    end
    bus.dcm_locked = 3'b110;
    tick();
    bus.dcm_locked = 3'b111;
    tick();
    tick();
    chk("t5_dom", bus.dom_rst, 7);
    chk("t5_dcm_rst", bus.dcm_rst, 1);
    chk("t5_rc_or_fault", RETRY ? int'(bus.retry_cnt) : int'(bus.fault), 1);

    // Reset mid-release.
    do_reset(3'b111);
    repeat (18) tick();
    chk("t6_dom_mid", bus.dom_rst, 3'b100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_dom", bus.dom_rst, 7);
    chk("t6_dcm_rst", bus.dcm_rst, 1);
    chk("t6_fault", bus.fault, 0);
    chk("t6_rdy", bus.ready, 0);

    // Random lock traffic with varied glitch density and occasional resets.
    for (int r = 0; r < 8; r++) begin
      int p;
      p = (r % 4 == 0) ? 0 : (r % 4 == 1) ? 1 : (r % 4 == 2) ? 3 : 20;
      do_reset(3'($urandom_range(0, 7)));
      for (int c = 0; c < 500; c++) begin
        bus.dcm_locked = ($urandom_range(0, 99) < p) ? 3'($urandom_range(0, 6)) : 3'b111;
        rst = ($urandom_range(0, 699) == 0);
        tick();
      end
      rst = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
